// File: rtl/inst_fetch_pkg.sv
// Shared defines for the fetch stage: stall bus width, reset level, zero word and FSM encoding.
package inst_fetch_pkg;

  localparam int unsigned StallBus = 6;
  localparam logic RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [0:0] {
    StFetch,
    StHold
  } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: pulls four bytes per instruction from a byte-wide memory port,
// assembles them little-endian and holds the result until if_id takes it.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] START_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall_sign,
  input  logic                branch_flag_i,
  input  logic [31:0]         branch_addr_i,
  output logic                if_req_o,
  output logic [31:0]         if_addr_o,
  input  logic                if_gnt_i,
  input  logic                if_rvalid_i,
  input  logic [7:0]          if_rdata_i,
  output logic [31:0]         pc_o,
  output logic [31:0]         inst_o,
  output logic                inst_valid_o
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [2:0]  issue_cnt_q;
  logic [2:0]  recv_cnt_q;
  logic        outstanding_q;
  logic        drop_q;
  logic        valid_q;

  logic accept;
  logic byte_in;
  logic handoff;

  // The request is combinational so a redirect can suppress it in the same cycle.
  always_comb begin
    if_req_o  = (rst != RstEnable) && (state_q == StFetch) && !branch_flag_i &&
                !stall_sign[0] && (issue_cnt_q < 3'd4);
    if_addr_o = if_req_o ? (pc_q + {29'b0, issue_cnt_q}) : ZeroWord;
    accept    = if_req_o && if_gnt_i;
    byte_in   = if_rvalid_i && outstanding_q && !drop_q && (recv_cnt_q < 3'd4);
    handoff   = (state_q == StHold) && !stall_sign[1];
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q       <= StFetch;
      pc_q          <= START_PC;
      inst_q        <= ZeroWord;
      issue_cnt_q   <= 3'd0;
      recv_cnt_q    <= 3'd0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      valid_q       <= 1'b0;
    end else if (branch_flag_i) begin
      state_q     <= StFetch;
      pc_q        <= {branch_addr_i[31:2], 2'b00};
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      valid_q     <= 1'b0;
      // A byte still in flight belongs to the old stream and must be discarded on arrival.
      outstanding_q <= outstanding_q && !if_rvalid_i;
      drop_q        <= outstanding_q && !if_rvalid_i;
    end else begin
      outstanding_q <= accept || (outstanding_q && !if_rvalid_i);
      drop_q        <= drop_q && !if_rvalid_i;
      if (accept) begin
        issue_cnt_q <= issue_cnt_q + 3'd1;
      end
      if (byte_in) begin
        inst_q[{recv_cnt_q[1:0], 3'b000} +: 8] <= if_rdata_i;
        recv_cnt_q <= recv_cnt_q + 3'd1;
        if (recv_cnt_q == 3'd3) begin
          state_q <= StHold;
          valid_q <= 1'b1;
        end
      end
      if (handoff) begin
        state_q     <= StFetch;
        pc_q        <= pc_q + 32'd4;
        issue_cnt_q <= 3'd0;
        recv_cnt_q  <= 3'd0;
        valid_q     <= 1'b0;
      end
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised bench for inst_fetch: the bench plays the byte memory, a request-level model
// predicts addresses and hold timing, and a monitor scores each delivered instruction.
module tb_inst_fetch;

  localparam logic [31:0] StartPc = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_sign = 6'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        if_gnt_i = 1'b0;
  logic        if_rvalid_i = 1'b0;
  logic [7:0]  if_rdata_i = 8'h0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  inst_fetch #(.START_PC(StartPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_sign   (stall_sign),
    .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i),
    .if_req_o     (if_req_o),
    .if_addr_o    (if_addr_o),
    .if_gnt_i     (if_gnt_i),
    .if_rvalid_i  (if_rvalid_i),
    .if_rdata_i   (if_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: current fetch PC, requests accepted and bytes received for it.
  logic [31:0] m_pc;
  int          m_issued;
  int          m_recv;
  logic        due = 1'b0;
  logic [31:0] due_addr = 32'h0;
  logic        stray = 1'b0;
  logic [31:0] qpc[$];
  logic [31:0] qinst[$];

  function automatic logic [7:0] mem(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[7:0];
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    qpc.push_back(pc);
    qinst.push_back({mem(pc + 32'd3), mem(pc + 32'd2), mem(pc + 32'd1), mem(pc)});
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic cycle(input logic [5:0] st, input logic br, input logic [31:0] ba,
                       input logic g);
    logic hold;
    logic exp_req;
    logic deliver;
    logic due_n;
    logic [31:0] due_addr_n;
    stall_sign    = st;
    branch_flag_i = br;
    branch_addr_i = ba;
    if_gnt_i      = g;
    if_rvalid_i   = due || stray;
    if_rdata_i    = due ? mem(due_addr) : 8'hEE;
    stray         = 1'b0;
    #1;
    hold    = (m_recv == 4);
    exp_req = !rst && !br && !hold && (m_issued < 4) && !st[0];
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, hold});
    chk("if_req", {31'b0, if_req_o}, {31'b0, exp_req});
    if (exp_req) chk("if_addr", if_addr_o, m_pc + m_issued);
    if (!if_req_o) chk("if_addr_idle", if_addr_o, 32'h0);
    deliver    = due && !br && !rst;
    due_n      = if_req_o && g;
    due_addr_n = if_addr_o;
    if (rst) begin
      m_pc = StartPc; m_issued = 0; m_recv = 0;
      qpc.delete(); qinst.delete();
      push_exp(m_pc);
    end else if (br) begin
      m_pc = {ba[31:2], 2'b00}; m_issued = 0; m_recv = 0;
      if (!hold && qpc.size() > 0) begin
        void'(qpc.pop_back()); void'(qinst.pop_back());
      end
      push_exp(m_pc);
    end else if (hold && !st[1]) begin
      m_pc = m_pc + 32'd4; m_issued = 0; m_recv = 0;
      push_exp(m_pc);
    end else begin
      if (exp_req && g) m_issued++;
      if (deliver) m_recv++;
    end
    due      = due_n;
    due_addr = due_addr_n;
    @(negedge clk);
  endtask

  task automatic fetch_until_hold(input logic [5:0] st, input logic toggle);
    for (int i = 0; i < 40; i++) begin
      if (m_recv == 4) break;
      cycle(st, 1'b0, 32'h0, toggle ? (i % 2 == 0) : 1'b1);
    end
    chk("hold_reached", {31'b0, inst_valid_o}, 32'd1);
  endtask

  // Monitor: scores each new instruction and checks it stays put while held.
  logic        prev_v = 1'b0;
  logic [31:0] cur_pc = 32'h0;
  logic [31:0] cur_inst = 32'h0;
  always @(posedge clk) begin
    #2;
    if (inst_valid_o && !prev_v) begin
      if (qpc.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        cur_pc   = qpc.pop_front();
        cur_inst = qinst.pop_front();
        chk("pc_o", pc_o, cur_pc);
        chk("inst_o", inst_o, cur_inst);
      end
    end else if (inst_valid_o) begin
      chk("pc_o_stable", pc_o, cur_pc);
      chk("inst_o_stable", inst_o, cur_inst);
    end
    prev_v = inst_valid_o;
  end

  initial begin
    m_pc = StartPc; m_issued = 0; m_recv = 0;
    @(negedge clk);
    cycle(6'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_pc_o", pc_o, StartPc);
    chk("rst_inst_o", inst_o, 32'h0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_req", {31'b0, if_req_o}, 32'd0);
    chk("rst_addr", if_addr_o, 32'h0);
    rst = 1'b0;

    // Best-case fetch, then hold under stall_sign[1] for three cycles before handoff.
    fetch_until_hold(6'b000010, 1'b0);
    chk("first_inst", inst_o, 32'h0010_0513);
    for (int i = 0; i < 3; i++) cycle(6'b000010, 1'b0, 32'h0, 1'b1);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);

    // Grant toggling.
    fetch_until_hold(6'b000010, 1'b1);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);

    // IF stall mid-fetch with a byte outstanding.
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);
    cycle(6'b000001, 1'b0, 32'h0, 1'b1);
    cycle(6'b000001, 1'b0, 32'h0, 1'b1);
    fetch_until_hold(6'b000010, 1'b0);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);

    // Redirect after two bytes; the in-flight byte is stale.
    for (int i = 0; i < 3; i++) cycle(6'b000000, 1'b0, 32'h0, 1'b1);
    cycle(6'b000001, 1'b1, 32'h1002, 1'b1);
    fetch_until_hold(6'b000010, 1'b0);
    chk("branch_pc", pc_o, 32'h1000);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);

    // PC wrap from the top of the address space.
    cycle(6'b000000, 1'b1, 32'hFFFF_FFFE, 1'b1);
    fetch_until_hold(6'b000010, 1'b0);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);
    fetch_until_hold(6'b000010, 1'b0);
    chk("wrap_pc", pc_o, 32'h0);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);

    // Reset mid-fetch, then a stray read byte in the first cycle after it.
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    stray = 1'b1;
    fetch_until_hold(6'b000010, 1'b0);
    chk("post_rst_inst", inst_o, 32'h0010_0513);
    cycle(6'b000000, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] st;
      logic br;
      st  = {4'b0, ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0)};
      br  = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle(st, br, $urandom, ($urandom_range(0, 9) < 7));
    end
    rst = 1'b0;

    fetch_until_hold(6'b000010, 1'b0);
    cycle(6'b000010, 1'b0, 32'h0, 1'b1);
    chk("scoreboard_drained", qpc.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
